// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore sequencer for a multi-cycle MIPS datapath.
// It walks each instruction through fetch/decode/execute/memory/writeback
// and drives every datapath strobe and mux select.
// Optional feature macro: MC_CTRL_STAT_EN adds cycle_cnt / instr_cnt
// statistics outputs; without it those ports and counters do not exist.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | load IR, PC <= PC+4
// S_DECODE | classify opcode/funct, flag unsupported encodings
// S_EXE    | ALU operation for R-type, ori, lui and address calc for lw/sw
// S_MEM    | data memory access, held for MEM_WAIT extra cycles
// S_WB     | register file write for ALU results and lw data
// S_BR     | beq: PC <= branch target when zero is set
// S_JMP    | jal (link to $31) / jr (PC <= rs)
// 7..15    | unreachable; recover to S_FETCH
//
// Outputs are decoded from the state register together with the live IR
// fields. IR only loads at the end of S_FETCH, so decode-cycle outputs
// (ext_op, illegal) cannot be pre-registered one cycle earlier.
module multi_cycle_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             mem_wr,
  output logic             ext_op,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [1:0]       npc_op,
  output logic [3:0]       state,
  output logic             illegal
`ifdef MC_CTRL_STAT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_BR     = 4'd5,
    S_JMP    = 4'd6
  } state_t;

  typedef enum logic [3:0] {
    I_NOP,
    I_ADDU,
    I_SUBU,
    I_JR,
    I_ORI,
    I_LUI,
    I_LW,
    I_SW,
    I_BEQ,
    I_JAL,
    I_ILL
  } instr_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  // Reject parameter values the 4-bit wait counter or counters cannot hold
  if (MEM_WAIT < 0 || MEM_WAIT > 15 || CNT_W < 1) begin : g_param_chk
    $error("multi_cycle_ctrl: MEM_WAIT must be 0..15 and CNT_W >= 1");
  end

  state_t     state_q;
  logic [3:0] wait_cnt;
  instr_t     instr;
  logic       ext_sel;

  logic       pc_wr_c;
  logic       ir_wr_c;
  logic       reg_wr_c;
  logic       mem_wr_c;
  logic       ext_op_c;
  logic       alu_src_c;
  logic [2:0] alu_op_c;
  logic [1:0] reg_dst_c;
  logic [1:0] wd_sel_c;
  logic [1:0] npc_op_c;
  logic       illegal_c;

  // Classify the instruction held in IR
  always_comb begin
    instr = I_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: instr = I_ADDU;
          FN_SUBU: instr = I_SUBU;
          FN_JR:   instr = I_JR;
          FN_NOP:  instr = I_NOP;
          default: instr = I_ILL;
        endcase
      end
      OP_ORI:  instr = I_ORI;
      OP_LUI:  instr = I_LUI;
      OP_LW:   instr = I_LW;
      OP_SW:   instr = I_SW;
      OP_BEQ:  instr = I_BEQ;
      OP_JAL:  instr = I_JAL;
      default: instr = I_ILL;
    endcase
  end

  // Sign-extend only for the offset-carrying instructions
  always_comb begin
    ext_sel = (instr == I_LW) || (instr == I_SW) || (instr == I_BEQ);
  end

  // State sequencing and the S_MEM wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= 4'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (instr)
            I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW: state_q <= S_EXE;
            I_BEQ:                                    state_q <= S_BR;
            I_JAL, I_JR:                              state_q <= S_JMP;
            default:                                  state_q <= S_FETCH;
          endcase
        end
        S_EXE: begin
          wait_cnt <= 4'd0;
          if (instr == I_LW || instr == I_SW) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 4'd0;
            state_q  <= (instr == I_LW) ? S_WB : S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_BR:    state_q <= S_FETCH;
        S_JMP:   state_q <= S_FETCH;
        default: begin
          state_q  <= S_FETCH;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Per-state strobe and select decode
  always_comb begin
    pc_wr_c   = 1'b0;
    ir_wr_c   = 1'b0;
    reg_wr_c  = 1'b0;
    mem_wr_c  = 1'b0;
    ext_op_c  = 1'b0;
    alu_src_c = 1'b0;
    alu_op_c  = 3'd0;
    reg_dst_c = 2'd0;
    wd_sel_c  = 2'd0;
    npc_op_c  = 2'd0;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr_c = 1'b1;
        pc_wr_c = 1'b1;
      end
      S_DECODE: begin
        ext_op_c  = ext_sel;
        illegal_c = (instr == I_ILL);
      end
      S_EXE: begin
        ext_op_c = ext_sel;
        case (instr)
          I_SUBU:      alu_op_c = 3'd1;
          I_ORI:       alu_op_c = 3'd2;
          I_LUI:       alu_op_c = 3'd3;
          default:     alu_op_c = 3'd0;
        endcase
        alu_src_c = (instr == I_ORI) || (instr == I_LUI) ||
                    (instr == I_LW)  || (instr == I_SW);
      end
      S_MEM: begin
        ext_op_c = ext_sel;
        // a write must hit DM exactly once, however long the access waits
        mem_wr_c = (instr == I_SW) && (wait_cnt == 4'd0);
      end
      S_WB: begin
        ext_op_c = ext_sel;
        reg_wr_c = 1'b1;
        case (instr)
          I_ADDU, I_SUBU: begin
            reg_dst_c = 2'd1;
            wd_sel_c  = 2'd0;
          end
          I_LW: begin
            reg_dst_c = 2'd0;
            wd_sel_c  = 2'd1;
          end
          default: begin
            reg_dst_c = 2'd0;
            wd_sel_c  = 2'd0;
          end
        endcase
      end
      S_BR: begin
        ext_op_c = ext_sel;
        npc_op_c = 2'd1;
        pc_wr_c  = zero;
      end
      S_JMP: begin
        ext_op_c = ext_sel;
        pc_wr_c  = 1'b1;
        if (instr == I_JAL) begin
          npc_op_c  = 2'd2;
          reg_wr_c  = 1'b1;
          reg_dst_c = 2'd2;
          wd_sel_c  = 2'd2;
        end else begin
          npc_op_c = 2'd3;
        end
      end
      default: begin
        pc_wr_c = 1'b0;
      end
    endcase
  end

  // Reset blanks every output immediately, before the synchronous edge lands
  always_comb begin
    pc_wr   = reset ? 1'b0 : pc_wr_c;
    ir_wr   = reset ? 1'b0 : ir_wr_c;
    reg_wr  = reset ? 1'b0 : reg_wr_c;
    mem_wr  = reset ? 1'b0 : mem_wr_c;
    ext_op  = reset ? 1'b0 : ext_op_c;
    alu_src = reset ? 1'b0 : alu_src_c;
    alu_op  = reset ? 3'd0 : alu_op_c;
    reg_dst = reset ? 2'd0 : reg_dst_c;
    wd_sel  = reset ? 2'd0 : wd_sel_c;
    npc_op  = reset ? 2'd0 : npc_op_c;
    illegal = reset ? 1'b0 : illegal_c;
    state   = reset ? 4'd0 : state_q;
  end

`ifdef MC_CTRL_STAT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  // Free-running statistics; both wrap naturally at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == S_FETCH) begin
        instr_q <= instr_q + CNT_W'(1);
      end
    end
  end

  // Counters read as zero while reset is held, like every other output
  always_comb begin
    cycle_cnt = reset ? '0 : cycle_q;
    instr_cnt = reset ? '0 : instr_q;
  end
`endif

endmodule
